poc_mc: RTL and testbench

Parametrised multi-channel parallel output controller, the successor to the single-channel POC. It sits between the processor register bus and NUM_CH print modules. Each channel has a byte FIFO that decouples processor writes from the printer handshake. The block raises one level interrupt when any enabled channel has drained, and supports polled operation when interrupts are disabled.

---
 rtl/poc_mc.sv | 190 +++++++++++++++++++
 tb/tb_poc_mc.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poc_mc.sv
// poc_mc: multi-channel parallel output controller.
// Register-bus writes fill per-channel FIFOs drained by a printer handshake FSM.
module poc_mc #(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     irq,
    input  logic [NUM_CH-1:0]        print_ready,
    output logic [NUM_CH*DATA_W-1:0] print_data,
    output logic [NUM_CH-1:0]        pulse_request
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CHSEL = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_DATA  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_PEND  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CLR   = ADDR_W'(5);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LO = 2'd1,
        WAIT_HI = 2'd2
    } ch_state_t;

    logic              irq_en;
    logic [CW-1:0]     ch_sel;
    logic              wr_data;
    logic              wr_clr;
    logic              rd_pend;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] pending;
    logic [LW-1:0]     lvl_a [NUM_CH];
    logic [LW-1:0]     sel_lvl;
    logic              sel_ovf;
    logic [7:0]        rd8;

    assign wr_data = wr_en && (addr == A_DATA);
    assign wr_clr  = wr_en && (addr == A_CLR);
    assign rd_pend = rd_en && (addr == A_PEND);

    always_comb begin
        push = '0;
        for (int i = 0; i < NUM_CH; i++)
            push[i] = wr_data && (ch_sel == CW'(i));
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0]     wptr;
        logic [PW-1:0]     rptr;
        logic [LW-1:0]     level;
        ch_state_t         state;
        logic [DATA_W-1:0] pdata;
        logic              pulse;
        logic              ov;
        logic              pend;
        logic              do_pop;
        logic              do_push;
        logic              is_full;
        logic              pend_set;
        logic              clr_hit;

        if (i < DATA_W) begin : g_clr
            assign clr_hit = wr_clr & wdata[i];
        end else begin : g_noclr
            assign clr_hit = 1'b0;
        end

        assign do_pop   = (state == IDLE) && (level != '0) && print_ready[i];
        assign is_full  = (level == LW'(FIFO_DEPTH));
        // A pop in the same cycle frees the slot a full FIFO needs.
        assign do_push  = push[i] && (!is_full || do_pop);
        assign pend_set = (state == WAIT_HI) && print_ready[i] && (level == '0);

        always_ff @(posedge clk) begin
            if (do_push)
                mem[wptr] <= wdata;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
                ov    <= 1'b0;
                pend  <= 1'b0;
            end else begin
                if (do_push)
                    wptr <= wptr + 1'b1;
                if (do_pop)
                    rptr <= rptr + 1'b1;
                level <= level + LW'(do_push) - LW'(do_pop);
                if (push[i] && !do_push)
                    ov <= 1'b1;
                else if (clr_hit)
                    ov <= 1'b0;
                if (push[i])
                    pend <= 1'b0;
                else if (pend_set)
                    pend <= 1'b1;
                else if (rd_pend)
                    pend <= 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= IDLE;
                pdata <= '0;
                pulse <= 1'b0;
            end else begin
                pulse <= 1'b0;
                unique case (state)
                    IDLE: begin
                        if (do_pop) begin
                            pdata <= mem[rptr];
                            pulse <= 1'b1;
                            state <= WAIT_LO;
                        end
                    end
                    WAIT_LO: if (!print_ready[i]) state <= WAIT_HI;
                    WAIT_HI: if (print_ready[i]) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end

        assign lvl_a[i]                       = level;
        assign ovf[i]                         = ov;
        assign pending[i]                     = pend;
        assign print_data[i*DATA_W +: DATA_W] = pdata;
        assign pulse_request[i]               = pulse;
    end

    always_comb begin
        sel_lvl = '0;
        sel_ovf = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CW'(i)) begin
                sel_lvl = lvl_a[i];
                sel_ovf = ovf[i];
            end
        end
    end

    always_comb begin
        rd8 = '0;
        case (addr)
            A_CTRL:  rd8 = {7'd0, irq_en};
            A_CHSEL: rd8 = 8'(ch_sel);
            A_STAT:  rd8 = {5'(sel_lvl), sel_ovf, sel_lvl == '0,
                            sel_lvl == LW'(FIFO_DEPTH)};
            A_PEND:  rd8 = 8'(pending);
            default: rd8 = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 1'b0;
            ch_sel <= '0;
            rdata  <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr_en && addr == A_CTRL)
                irq_en <= wdata[0];
            if (wr_en && addr == A_CHSEL && int'(wdata) < NUM_CH)
                ch_sel <= CW'(wdata);
            if (rd_en)
                rdata <= rd8[DATA_W-1:0];
            irq <= irq_en & (|pending);
        end
    end

endmodule

// File: tb/tb_poc_mc.sv
// tb_poc_mc: scoreboard bench for poc_mc.
// Expected printer bytes are queued per channel and popped by a pulse monitor.
module tb_poc_mc;

    localparam int DW = 8;
    localparam int NC = 2;
    localparam int FD = 4;
    localparam int AW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [AW-1:0]  addr = '0;
    logic           wr_en = 1'b0;
    logic           rd_en = 1'b0;
    logic [DW-1:0]  wdata = '0;
    logic [DW-1:0]  rdata;
    logic           irq;
    wire  [NC-1:0]  print_ready;
    logic [NC*DW-1:0] print_data;
    logic [NC-1:0]  pulse_request;

    logic [NC-1:0]  auto_pr = '0;
    logic [NC-1:0]  man_ready = '0;
    wire  [NC-1:0]  busy;

    always #5 clk = ~clk;

    poc_mc #(.DATA_W(DW), .NUM_CH(NC), .FIFO_DEPTH(FD), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wdata(wdata), .rdata(rdata), .irq(irq), .print_ready(print_ready),
        .print_data(print_data), .pulse_request(pulse_request)
    );

    int checks = 0;
    int errors = 0;
    longint cyc = 0;
    longint last_p [NC];

    // Reference model state
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [NC-1:0] ov_m = '0;
    logic [NC-1:0] pend_m = '0;
    logic [NC-1:0] dirty = '0;
    logic en_m = 1'b0;
    int sel_m = 0;

    function automatic int qsz(input int c);
        return (c == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] st_exp(input int c);
        int l;
        l = qsz(c);
        return {l[4:0], ov_m[c], l == 0, l == FD};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Printer models: acknowledge each pulse with a random-length low phase.
    for (genvar g = 0; g < NC; g++) begin : g_pr
        logic r = 1'b1;
        logic b = 1'b0;
        initial forever begin
            @(posedge clk);
            #1;
            if (auto_pr[g] && pulse_request[g] === 1'b1) begin
                b = 1'b1;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                @(negedge clk);
                r = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                r = 1'b1;
                @(negedge clk);
                b = 1'b0;
            end
        end
        assign print_ready[g] = auto_pr[g] ? r : man_ready[g];
        assign busy[g] = b;
    end

    // Monitor: every pulse must carry the next expected byte for its channel.
    always @(posedge clk) begin
        cyc++;
        #1;
        for (int c = 0; c < NC; c++) begin
            if (pulse_request[c] === 1'b1) begin
                logic [7:0] got;
                logic [7:0] exp;
                got = print_data[c*DW +: DW];
                checks++;
                if (qsz(c) == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse ch%0d: got=%02h expected=none", c, got);
                end else begin
                    exp = (c == 0) ? q0.pop_front() : q1.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL print_data ch%0d: got=%02h expected=%02h", c, got, exp);
                    end
                end
                checks++;
                if (cyc - last_p[c] < 3) begin
                    errors++;
                    $display("FAIL pulse_spacing ch%0d: got=%0d expected>=3", c, cyc - last_p[c]);
                end
                last_p[c] = cyc;
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        if (a == 3'd0) en_m = d[0];
        if (a == 3'd1 && int'(d) < NC) sel_m = int'(d);
        if (a == 3'd5) ov_m = ov_m & ~d[NC-1:0];
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = rdata;
    endtask

    // A full FIFO accepts the byte only if a pop happens on the same edge.
    task automatic push(input logic [7:0] d);
        int pre;
        logic acc;
        addr = 3'd2; wdata = d; wr_en = 1'b1;
        pre = qsz(sel_m);
        @(posedge clk);
        #2;
        acc = (pre < FD) || (pulse_request[sel_m] === 1'b1);
        if (acc) begin
            if (sel_m == 0) q0.push_back(d); else q1.push_back(d);
        end else begin
            ov_m[sel_m] = 1'b1;
        end
        dirty[sel_m] = 1'b1;
        pend_m[sel_m] = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_q_empty(input int c, input int lim);
        int n;
        n = 0;
        while (qsz(c) != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("pulse_seen", qsz(c) == 0, 1);
    endtask

    task automatic drain_all();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy != '0 ||
                (print_ready & auto_pr) != auto_pr) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", n < 300, 1);
        repeat (4) @(negedge clk);
        pend_m = pend_m | dirty;
        dirty = '0;
    endtask

    task automatic chk_irq();
        repeat (2) @(negedge clk);
        chk("irq", irq, en_m & (|pend_m));
    endtask

    task automatic chk_pend();
        logic [7:0] d;
        logic [7:0] e;
        e = 8'(pend_m);
        rd(3'd4, d);
        chk("pend", d, e);
        pend_m = '0;
    endtask

    initial begin
        logic [7:0] d;
        int n;
        for (int c = 0; c < NC; c++) last_p[c] = -100;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_irq", irq, 0);
        chk("rst_pulse", pulse_request, 0);
        chk("rst_pdata", print_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        rd(3'd3, d);
        chk("status_after_reset", d, 8'h02);

        // Reset in the middle of a transfer
        man_ready[0] = 1'b1;
        push(8'h41);
        wait_q_empty(0, 10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_pdata", print_data, 0);
        chk("midrst_pulse", pulse_request, 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_irq", irq, 0);
        q0.delete(); q1.delete();
        ov_m = '0; pend_m = '0; dirty = '0; en_m = 1'b0; sel_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        rd(3'd3, d);
        chk("midrst_status", d, st_exp(0));
        man_ready[0] = 1'b0;

        // Single byte on ch1 with interrupt
        wr(3'd0, 8'h01);
        wr(3'd1, 8'h01);
        man_ready[1] = 1'b1;
        push(8'h55);
        wait_q_empty(1, 10);
        man_ready[1] = 1'b0;
        repeat (2) @(negedge clk);
        man_ready[1] = 1'b1;
        drain_all();
        chk_irq();
        rd(3'd4, d);
        chk("pend_ch1", d, 8'(pend_m));
        pend_m = '0;
        @(negedge clk);
        chk("irq_drop", irq, 0);

        // Overflow with printer stalled
        wr(3'd1, 8'h00);
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        rd(3'd3, d);
        chk("status_ovf", d, st_exp(0));
        auto_pr[0] = 1'b1;
        drain_all();
        rd(3'd3, d);
        chk("status_drained", d, st_exp(0));
        wr(3'd5, 8'h01);
        rd(3'd3, d);
        chk("status_clr", d, st_exp(0));
        chk_irq();
        chk_pend();

        // Both channels concurrently
        auto_pr = '1;
        wr(3'd1, 8'h00);
        push(8'hA0);
        push(8'hA1);
        wr(3'd1, 8'h01);
        push(8'hB0);
        drain_all();
        chk_pend();

        // Push coinciding with a pop on a full FIFO
        auto_pr[0] = 1'b0;
        man_ready[0] = 1'b0;
        wr(3'd1, 8'h00);
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        rd(3'd3, d);
        chk("status_full", d, st_exp(0));
        man_ready[0] = 1'b1;
        push(8'h77);
        rd(3'd3, d);
        chk("status_pushpop", d, st_exp(0));
        for (int i = 0; i < 5; i++) begin
            man_ready[0] = 1'b0;
            @(negedge clk);
            man_ready[0] = 1'b1;
            repeat (3) @(negedge clk);
        end
        drain_all();
        chk_pend();

        // Invalid channel select and polled mode
        wr(3'd1, 8'h01);
        wr(3'd1, 8'h07);
        rd(3'd1, d);
        chk("chsel_7", d, 8'(sel_m));
        wr(3'd1, 8'h02);
        rd(3'd1, d);
        chk("chsel_2", d, 8'(sel_m));
        wr(3'd0, 8'h00);
        auto_pr[0] = 1'b1;
        wr(3'd1, 8'h00);
        push(8'h3C);
        drain_all();
        chk_irq();
        chk_pend();

        // Randomised traffic
        for (int it = 0; it < 16; it++) begin
            wr(3'd1, 8'($urandom_range(0, NC - 1)));
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                push(8'($urandom));
                repeat ($urandom_range(0, 1)) @(negedge clk);
            end
            wr(3'd0, 8'($urandom_range(0, 1)));
            drain_all();
            rd(3'd3, d);
            chk("rand_status", d, st_exp(sel_m));
            chk_irq();
            if ($urandom_range(0, 1) == 1) wr(3'd5, 8'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) chk_pend();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
